// File: rtl/tft_pkg.sv
// Shared TFT panel definitions: D/C levels, controller command codes, panel
// limits and byte-builder helpers used by the fill engine and init sequencer.
package tft_pkg;

  localparam logic COMM = 1'b0;
  localparam logic DATA = 1'b1;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int unsigned TFT_WIDTH  = 32'd320;
  localparam int unsigned TFT_HEIGHT = 32'd480;
  localparam logic [8:0]  X_MAX      = 9'(TFT_WIDTH - 32'd1);
  localparam logic [8:0]  Y_MAX      = 9'(TFT_HEIGHT - 32'd1);
  localparam logic [3:0]  HDR_LAST   = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    PIX   = 2'd2,
    DRAIN = 2'd3
  } fill_state_e;

  typedef struct packed {
    logic [8:0]  x0;
    logic [8:0]  x1;
    logic [8:0]  y0;
    logic [8:0]  y1;
    logic [17:0] color;
  } rect_t;

  // Window header byte {dc, data} for position idx of the 11-byte sequence.
  function automatic logic [8:0] hdr_byte(input logic [3:0] idx, input rect_t r);
    logic [8:0] b;
    case (idx)
      4'd0:    b = {COMM, CMD_CASET};
      4'd1:    b = {DATA, 7'd0, r.x0[8]};
      4'd2:    b = {DATA, r.x0[7:0]};
      4'd3:    b = {DATA, 7'd0, r.x1[8]};
      4'd4:    b = {DATA, r.x1[7:0]};
      4'd5:    b = {COMM, CMD_PASET};
      4'd6:    b = {DATA, 7'd0, r.y0[8]};
      4'd7:    b = {DATA, r.y0[7:0]};
      4'd8:    b = {DATA, 7'd0, r.y1[8]};
      4'd9:    b = {DATA, r.y1[7:0]};
      4'd10:   b = {COMM, CMD_RAMWR};
      default: b = {COMM, 8'h00};
    endcase
    return b;
  endfunction

  // RGB666 component left-justified in a data byte: comp 0=r, 1=g, 2=b.
  function automatic logic [8:0] pix_byte(input logic [1:0] comp, input logic [17:0] color);
    logic [8:0] b;
    case (comp)
      2'd0:    b = {DATA, color[17:12], 2'b00};
      2'd1:    b = {DATA, color[11:6], 2'b00};
      2'd2:    b = {DATA, color[5:0], 2'b00};
      default: b = {DATA, 8'h00};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tft_byte_pacer.sv
// Byte send pacing: one-cycle transmit pulses, a mandatory idle cycle after
// each pulse, and no pulse while the byte transmitter reports busy.
module tft_byte_pacer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       dc,
  input  logic [7:0] data,
  input  logic       tft_busy,
  output logic       ack,
  output logic       line_idle,
  output logic       tft_transmit,
  output logic       tft_dc,
  output logic [7:0] tft_data
);

  logic       pulse_r;
  logic       dc_r;
  logic [7:0] data_r;

  assign line_idle    = ~tft_busy & ~pulse_r;
  assign ack          = req & line_idle;
  assign tft_transmit = pulse_r;
  assign tft_dc       = dc_r;
  assign tft_data     = data_r;

  // Pulse and byte register; dc/data only change alongside a new pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_r <= 1'b0;
      dc_r    <= 1'b0;
      data_r  <= 8'h00;
    end else begin
      pulse_r <= ack;
      if (ack) begin
        dc_r   <= dc;
        data_r <= data;
      end
    end
  end

endmodule

// File: rtl/tft_rect_fill.sv
// Rectangle fill engine: validates bounds, sends the CASET/PASET/RAMWR window
// header and then N RGB666 pixels, one byte at a time through the pacer.
module tft_rect_fill
  import tft_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        start,
  input  logic [8:0]  x0,
  input  logic [8:0]  x1,
  input  logic [8:0]  y0,
  input  logic [8:0]  y1,
  input  logic [17:0] color,
  input  logic        abort,
  input  logic        tft_busy,
  output logic        tft_transmit,
  output logic        tft_dc,
  output logic [7:0]  tft_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  fill_state_e state_r, next_state_s;
  rect_t       rect_r, rect_in_s;
  logic [3:0]  hdr_idx_r;
  logic [1:0]  comp_r;
  logic [17:0] pix_left_r;
  logic        aborted_r, busy_r, done_r, err_r;

  logic        req_s, ack_s, line_idle_s, accept_s, reject_s, bad_s, last_pix_byte_s;
  logic [8:0]  byte_s, w_s, h_s;
  logic [17:0] pix_total_s;

  assign rect_in_s       = '{x0: x0, x1: x1, y0: y0, y1: y1, color: color};
  assign bad_s           = (x0 > x1) | (y0 > y1) | (x1 > X_MAX) | (y1 > Y_MAX);
  assign w_s             = x1 - x0 + 9'd1;
  assign h_s             = y1 - y0 + 9'd1;
  assign pix_total_s     = 18'(w_s) * 18'(h_s);
  assign last_pix_byte_s = (comp_r == 2'd2) && (pix_left_r == 18'd1);
  // Abort gates the request so an abort always beats an eligible pulse.
  assign req_s           = ((state_r == HDR) || (state_r == PIX)) && !abort;

  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;

  // Byte currently offered to the pacer.
  always_comb begin
    byte_s = {COMM, 8'h00};
    if (state_r == PIX) begin
      byte_s = pix_byte(comp_r, rect_r.color);
    end else begin
      byte_s = hdr_byte(hdr_idx_r, rect_r);
    end
  end

  // Next-state and start acceptance/rejection decode.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    reject_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && init_done) begin
          if (bad_s) begin
            reject_s     = 1'b1;
            next_state_s = IDLE;
          end else begin
            accept_s     = 1'b1;
            next_state_s = HDR;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      HDR: begin
        if (abort) begin
          next_state_s = DRAIN;
        end else if (ack_s && (hdr_idx_r == HDR_LAST)) begin
          next_state_s = PIX;
        end else begin
          next_state_s = HDR;
        end
      end
      PIX: begin
        if (abort) begin
          next_state_s = DRAIN;
        end else if (ack_s && last_pix_byte_s) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = PIX;
        end
      end
      DRAIN: begin
        if (line_idle_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Latched parameters, byte/pixel counters and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rect_r     <= '0;
      hdr_idx_r  <= 4'd0;
      comp_r     <= 2'd0;
      pix_left_r <= 18'd0;
      aborted_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      err_r  <= reject_s;
      done_r <= (state_r == DRAIN) && line_idle_s && !aborted_r;
      busy_r <= (next_state_s != IDLE);
      if (accept_s) begin
        rect_r     <= rect_in_s;
        hdr_idx_r  <= 4'd0;
        comp_r     <= 2'd0;
        pix_left_r <= pix_total_s;
        aborted_r  <= 1'b0;
      end else if (ack_s && (state_r == HDR)) begin
        hdr_idx_r <= hdr_idx_r + 4'd1;
      end else if (ack_s && (state_r == PIX)) begin
        if (comp_r == 2'd2) begin
          comp_r     <= 2'd0;
          pix_left_r <= pix_left_r - 18'd1;
        end else begin
          comp_r <= comp_r + 2'd1;
        end
      end else if (abort && ((state_r == HDR) || (state_r == PIX))) begin
        aborted_r <= 1'b1;
      end
    end
  end

  tft_byte_pacer u_pacer (
    .clk          (clk),
    .rst          (rst),
    .req          (req_s),
    .dc           (byte_s[8]),
    .data         (byte_s[7:0]),
    .tft_busy     (tft_busy),
    .ack          (ack_s),
    .line_idle    (line_idle_s),
    .tft_transmit (tft_transmit),
    .tft_dc       (tft_dc),
    .tft_data     (tft_data)
  );

endmodule
